// File: rtl/mips_pkg.sv
// Shared types for the data-memory port arbiter: arbiter states, read-return owner tags
// and the data-memory geometry.
package mips_pkg;
    localparam int DMEM_ADDR_W = 7;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic {
        S_CORE,
        S_DMA
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CORE,
        OWN_DMA
    } arb_owner_e;
endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Core, loader and memory-array signals of the data-memory arbiter; slave = arbiter side,
// master = requesters plus memory array.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_stall;
    logic              core_rvalid;
    logic [DATA_W-1:0] core_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output core_stall, core_rvalid, core_rdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  core_stall, core_rvalid, core_rdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_port_arbiter_sat_counter.sv
// Saturating event counter; at_limit flags the increment that reaches LIMIT so the owner can
// act in that same cycle.
module dmem_sat_counter #(
    parameter int W     = 4,
    parameter int LIMIT = 8
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);
    localparam logic [W-1:0] LIM    = W'(LIMIT);
    localparam logic [W-1:0] LIM_M1 = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    assign at_limit = inc && (cnt >= LIM_M1);

    always_ff @(posedge CLK) begin
        if (!RSTn || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIM)) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/dmem_port_arbiter.sv
// Core-priority arbiter for the single-port data memory with starvation-forced loader bursts;
// read data returns to the granted requester one cycle after its grant.
module dmem_port_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W        = DMEM_ADDR_W,
    parameter int DATA_W        = DMEM_DATA_W,
    parameter int STARVE_LIMIT  = 8,
    parameter int DMA_MAX_BURST = 4
) (
    input  logic                CLK,
    input  logic                RSTn,
    dmem_port_arbiter_if.slave  bus
);
    localparam int WAIT_W  = $clog2(STARVE_LIMIT + 1);
    localparam int BURST_W = $clog2(DMA_MAX_BURST + 1);

    arb_state_e        state;
    arb_owner_e        owner;
    logic [DATA_W-1:0] core_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;

    logic core_gnt;
    logic dma_gnt;
    logic wait_inc;
    logic starve;
    logic burst_inc;
    logic burst_lim;
    logic burst_end;
    logic core_rvalid;
    logic dma_rvalid;

    // Nothing is granted while reset is asserted.
    always_comb begin
        core_gnt = 1'b0;
        dma_gnt  = 1'b0;
        if (RSTn) begin
            if (state == S_CORE) begin
                core_gnt = bus.core_req;
                dma_gnt  = bus.dma_req && !bus.core_req;
            end else begin
                dma_gnt  = bus.dma_req;
                core_gnt = bus.core_req && !bus.dma_req;
            end
        end
    end

    assign wait_inc  = bus.dma_req && !dma_gnt;
    assign burst_inc = (state == S_DMA) && dma_gnt;
    assign burst_end = (state == S_DMA) && (burst_lim || !bus.dma_req);

    dmem_sat_counter #(.W(WAIT_W), .LIMIT(STARVE_LIMIT)) u_wait_cnt (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .clr      (!wait_inc || starve),
        .inc      (wait_inc),
        .at_limit (starve)
    );

    dmem_sat_counter #(.W(BURST_W), .LIMIT(DMA_MAX_BURST)) u_burst_cnt (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .clr      (burst_end),
        .inc      (burst_inc),
        .at_limit (burst_lim)
    );

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state        <= S_CORE;
            owner        <= OWN_NONE;
            core_rdata_q <= '0;
            dma_rdata_q  <= '0;
        end else begin
            case (state)
                S_CORE:  if (starve)    state <= S_DMA;
                S_DMA:   if (burst_end) state <= S_CORE;
                default:                state <= S_CORE;
            endcase

            if (core_gnt && !bus.core_we)    owner <= OWN_CORE;
            else if (dma_gnt && !bus.dma_we) owner <= OWN_DMA;
            else                             owner <= OWN_NONE;

            if (core_rvalid) core_rdata_q <= bus.mem_rdata;
            if (dma_rvalid)  dma_rdata_q  <= bus.mem_rdata;
        end
    end

    // Gating by RSTn drops a read still in flight when reset arrives.
    assign core_rvalid = RSTn && (owner == OWN_CORE);
    assign dma_rvalid  = RSTn && (owner == OWN_DMA);

    assign bus.core_stall  = bus.core_req && !core_gnt;
    assign bus.core_rvalid = core_rvalid;
    assign bus.core_rdata  = core_rvalid ? bus.mem_rdata : core_rdata_q;
    assign bus.dma_gnt     = dma_gnt;
    assign bus.dma_rvalid  = dma_rvalid;
    assign bus.dma_rdata   = dma_rvalid ? bus.mem_rdata : dma_rdata_q;

    assign bus.mem_en    = core_gnt || dma_gnt;
    assign bus.mem_we    = core_gnt ? bus.core_we    : (dma_gnt && bus.dma_we);
    assign bus.mem_addr  = core_gnt ? bus.core_addr  : bus.dma_addr;
    assign bus.mem_wdata = core_gnt ? bus.core_wdata : bus.dma_wdata;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized and directed bench for dmem_port_arbiter against a transaction-level model of
// grants, forced bursts and read returns.
module tb_dmem_port_arbiter;
    localparam int AW    = 7;
    localparam int DW    = 32;
    localparam int LIMIT = 8;
    localparam int BURST = 4;

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;
    always #5 CLK = ~CLK;

    dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT), .DMA_MAX_BURST(BURST)
    ) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    // Physical memory array behind the arbiter.
    logic [DW-1:0] ram [128];
    always @(posedge CLK) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: expected memory contents, burst bookkeeping, outstanding reads.
    logic [DW-1:0] ref_mem [128];
    bit            forced;
    int            refused_run;
    int            burst_grants;
    bit            pc, pd;
    logic [DW-1:0] pc_val, pd_val, hc, hd;
    bit            e_core, e_dma;
    bit            last_dma_gnt, last_core_stall;

    task automatic step();
        @(negedge CLK);
        e_core = 0;
        e_dma  = 0;
        if (RSTn) begin
            if (!forced) begin
                e_core = bus.core_req;
                e_dma  = bus.dma_req && !bus.core_req;
            end else begin
                e_dma  = bus.dma_req;
                e_core = bus.core_req && !bus.dma_req;
            end
        end
        last_dma_gnt    = bus.dma_gnt;
        last_core_stall = bus.core_stall;
        chk("core_stall", bus.core_stall, bus.core_req && !e_core);
        chk("dma_gnt", bus.dma_gnt, e_dma);
        chk("mem_en", bus.mem_en, e_core || e_dma);
        if (e_core) begin
            chk("mem_we_c", bus.mem_we, bus.core_we);
            chk("mem_addr_c", bus.mem_addr, bus.core_addr);
            if (bus.core_we) chk("mem_wdata_c", bus.mem_wdata, bus.core_wdata);
        end else if (e_dma) begin
            chk("mem_we_d", bus.mem_we, bus.dma_we);
            chk("mem_addr_d", bus.mem_addr, bus.dma_addr);
            if (bus.dma_we) chk("mem_wdata_d", bus.mem_wdata, bus.dma_wdata);
        end
        chk("core_rvalid", bus.core_rvalid, RSTn && pc);
        chk("core_rdata", bus.core_rdata, (RSTn && pc) ? pc_val : hc);
        chk("dma_rvalid", bus.dma_rvalid, RSTn && pd);
        chk("dma_rdata", bus.dma_rdata, (RSTn && pd) ? pd_val : hd);

        @(posedge CLK);
        if (!RSTn) begin
            forced = 0; refused_run = 0; burst_grants = 0;
            pc = 0; pd = 0; hc = '0; hd = '0;
        end else begin
            if (pc) hc = pc_val;
            if (pd) hd = pd_val;
            pc     = e_core && !bus.core_we;
            pc_val = ref_mem[bus.core_addr];
            pd     = e_dma && !bus.dma_we;
            pd_val = ref_mem[bus.dma_addr];
            if (e_core && bus.core_we) ref_mem[bus.core_addr] = bus.core_wdata;
            if (e_dma && bus.dma_we)   ref_mem[bus.dma_addr]  = bus.dma_wdata;
            if (!forced) begin
                if (bus.dma_req && !e_dma) begin
                    refused_run++;
                    if (refused_run == LIMIT) begin
                        forced      = 1;
                        refused_run = 0;
                    end
                end else begin
                    refused_run = 0;
                end
            end else begin
                if (e_dma) burst_grants++;
                if (burst_grants == BURST || !bus.dma_req) begin
                    forced       = 0;
                    burst_grants = 0;
                end
                refused_run = 0;
            end
        end
        #1;
    endtask

    task automatic set_core(input bit req, input bit we, input int addr, input logic [31:0] wd);
        bus.core_req = req; bus.core_we = we; bus.core_addr = AW'(addr); bus.core_wdata = wd;
    endtask

    task automatic set_dma(input bit req, input bit we, input int addr, input logic [31:0] wd);
        bus.dma_req = req; bus.dma_we = we; bus.dma_addr = AW'(addr); bus.dma_wdata = wd;
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        step();
        step();
        RSTn = 1'b1;
    endtask

    logic [31:0] pat;

    initial begin
        for (int i = 0; i < 128; i++) begin
            ram[i]     = 32'hA5A5_0000 ^ i;
            ref_mem[i] = 32'hA5A5_0000 ^ i;
        end
        ram[3]     = 32'h11;
        ref_mem[3] = 32'h11;
        bus.mem_rdata = '0;
        forced = 0; refused_run = 0; burst_grants = 0;
        pc = 0; pd = 0; pc_val = '0; pd_val = '0; hc = '0; hd = '0;

        // Requests during reset are refused.
        set_core(1, 0, 1, 0);
        set_dma(1, 0, 2, 0);
        do_reset();
        set_core(0, 0, 0, 0);
        set_dma(0, 0, 0, 0);
        step();
        chk("rst_core_rvalid", bus.core_rvalid, 0);
        chk("rst_core_rdata", bus.core_rdata, 0);
        chk("rst_dma_rdata", bus.dma_rdata, 0);

        // Core store then load of the same word.
        set_core(1, 1, 5, 32'hDEAD_BEEF);
        step();
        chk("t1_stall_st", last_core_stall, 0);
        set_core(1, 0, 5, 0);
        step();
        chk("t1_stall_ld", last_core_stall, 0);
        chk("t1_rvalid", bus.core_rvalid, 1);
        chk("t1_rdata", bus.core_rdata, 32'hDEAD_BEEF);
        set_core(0, 0, 0, 0);

        // Loader read of a preloaded word.
        set_dma(1, 0, 3, 0);
        step();
        chk("t2_gnt", last_dma_gnt, 1);
        chk("t2_rvalid", bus.dma_rvalid, 1);
        chk("t2_rdata", bus.dma_rdata, 32'h11);
        set_dma(0, 0, 0, 0);
        step();

        // Continuous contention: 8 core cycles, 4 forced loader cycles, repeating.
        do_reset();
        set_core(1, 0, 7, 0);
        set_dma(1, 0, 8, 0);
        pat = '0;
        for (int i = 0; i < 24; i++) begin
            step();
            pat[i] = last_dma_gnt;
        end
        chk("t3_pattern", pat, 32'h00F0_0F00);

        // Forced burst cut short after two loader grants.
        do_reset();
        for (int i = 0; i < LIMIT + 2; i++) step();
        set_dma(0, 0, 0, 0);
        step();
        chk("t4_stall_fall", last_core_stall, 0);
        set_dma(1, 0, 8, 0);
        step();
        chk("t4_core_back", last_dma_gnt, 0);
        set_dma(0, 0, 0, 0);
        set_core(0, 0, 0, 0);
        step();

        // Same-address writes: core first, loader write lands last.
        do_reset();
        set_core(1, 1, 9, 32'hA);
        set_dma(1, 1, 9, 32'hB);
        step();
        chk("t5_core_first", last_dma_gnt, 0);
        set_core(0, 0, 0, 0);
        step();
        chk("t5_dma_second", last_dma_gnt, 1);
        set_dma(0, 0, 0, 0);
        step();
        chk("t5_ram9", ram[9], 32'hB);
        set_core(1, 0, 9, 0);
        step();
        chk("t5_readback", bus.core_rdata, 32'hB);
        set_core(0, 0, 0, 0);

        // Reset in the middle of a forced burst with a loader read outstanding.
        do_reset();
        set_core(1, 0, 7, 0);
        set_dma(1, 0, 3, 0);
        for (int i = 0; i < LIMIT + 1; i++) step();
        chk("t6_in_burst", last_dma_gnt, 1);
        RSTn = 1'b0;
        step();
        chk("t6_no_rvalid_rst", last_dma_gnt, 0);
        RSTn = 1'b1;
        set_dma(0, 0, 0, 0);
        step();
        chk("t6_core_gnt", last_core_stall, 0);
        chk("t6_core_rvalid", bus.core_rvalid, 1);
        chk("t6_dma_rvalid", bus.dma_rvalid, 0);
        set_core(0, 0, 0, 0);
        step();

        // Random traffic on a small address window, occasional reset.
        for (int i = 0; i < 600; i++) begin
            RSTn = ($urandom % 80) != 0;
            set_core(($urandom % 4) != 0, $urandom % 2, $urandom % 16, $urandom);
            set_dma(($urandom % 3) != 0, $urandom % 2, $urandom % 16, $urandom);
            step();
        end
        RSTn = 1'b1;
        set_core(0, 0, 0, 0);
        set_dma(0, 0, 0, 0);
        step();
        for (int i = 0; i < 16; i++) chk("final_mem", ram[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
